// File: rtl/uc_run_ctrl.sv
// rtl/uc_run_ctrl.sv - run/step/breakpoint/reset sequencer gating the uC clock enable
module uc_run_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd,
  input  logic [7:0]           step_num,
  input  logic                 bp_en,
  input  logic [11:0]          bp_addr,
  input  logic [11:0]          pc_out,
  input  logic                 pc_valid,
  input  logic                 cu_state,
  input  logic                 flash_ready,
  output logic                 uc_clk_en,
  output logic                 uc_rst,
  output logic [1:0]           run_state,
  output logic                 bp_hit,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_RST  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HALT  = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_STEP  = 2'd2;
  localparam logic [1:0] CMD_RESET = 2'd3;
  localparam logic [3:0] RST_LOAD  = 4'(RST_CYCLES - 1);

  state_t     state;
  logic [7:0] step_rem;
  logic [3:0] rst_cnt;
  logic       skip_bp;
  logic       uc_rst_r;
  logic       active;
  logic       bp_stop;

  assign active    = (state == S_RUN) || (state == S_STEP);
  // skip_bp lets the first instruction after RUN/STEP execute even when parked on the breakpoint
  assign bp_stop   = bp_en & pc_valid & ~cu_state & (pc_out == bp_addr) & ~skip_bp;
  assign uc_clk_en = ~rst & active & (flash_ready | cu_state) & ~bp_stop;
  assign run_state = state;
  assign uc_rst    = uc_rst_r | rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HALT;
      uc_rst_r  <= 1'b0;
      bp_hit    <= 1'b0;
      done      <= 1'b0;
      cycle_cnt <= '0;
      skip_bp   <= 1'b0;
      step_rem  <= 8'd0;
      rst_cnt   <= 4'd0;
    end else begin
      done <= 1'b0;
      if (uc_clk_en) begin
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
        skip_bp   <= 1'b0;
      end

      if (cmd_valid && cmd == CMD_RESET) begin
        state     <= S_RST;
        uc_rst_r  <= 1'b1;
        rst_cnt   <= RST_LOAD;
        cycle_cnt <= '0;
        bp_hit    <= 1'b0;
        skip_bp   <= 1'b0;
        step_rem  <= 8'd0;
      end else if (state == S_RST) begin
        if (rst_cnt == 4'd0) begin
          state    <= S_HALT;
          uc_rst_r <= 1'b0;
        end else begin
          rst_cnt <= rst_cnt - 4'd1;
        end
      end else if (cmd_valid) begin
        // a command overrides any same-cycle retire or breakpoint event
        case (cmd)
          CMD_HALT: state <= S_HALT;
          CMD_RUN: begin
            state   <= S_RUN;
            bp_hit  <= 1'b0;
            skip_bp <= 1'b1;
          end
          CMD_STEP: begin
            bp_hit   <= 1'b0;
            skip_bp  <= 1'b1;
            step_rem <= step_num;
            if (step_num == 8'd0) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end
          default: ;
        endcase
      end else if (active && bp_stop) begin
        state  <= S_HALT;
        bp_hit <= 1'b1;
        done   <= 1'b1;
      end else if (state == S_STEP && uc_clk_en && cu_state) begin
        step_rem <= step_rem - 8'd1;
        if (step_rem == 8'd1) begin
          state <= S_HALT;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uc_run_ctrl.sv
// tb/tb_uc_run_ctrl.sv - directed and randomized checks of uc_run_ctrl against a behavioural model
module tb_uc_run_ctrl;
  localparam int RST_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, bp_en, pc_valid, cu_state, flash_ready;
  logic [1:0]  cmd;
  logic [7:0]  step_num;
  logic [11:0] bp_addr, pc_out;
  logic        uc_clk_en, uc_rst, bp_hit, done;
  logic [1:0]  run_state;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  // model: mode 0 halt, 1 run, 2 step, 3 reset hold
  int          m_mode = 0;
  int          m_rem = 0;
  int          m_left = 0;
  bit          m_skip = 0;
  bit          m_bp = 0;
  bit          m_done = 0;
  logic [31:0] m_cnt = 0;

  always #5 clk = ~clk;

  uc_run_ctrl #(.CNT_WIDTH(32), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .step_num(step_num),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_out(pc_out), .pc_valid(pc_valid),
    .cu_state(cu_state), .flash_ready(flash_ready), .uc_clk_en(uc_clk_en),
    .uc_rst(uc_rst), .run_state(run_state), .bp_hit(bp_hit), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  function automatic bit m_bpstop();
    return bp_en && pc_valid && !cu_state && (pc_out == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_en();
    return !rst && (m_mode == 1 || m_mode == 2) && (flash_ready || cu_state) && !m_bpstop();
  endfunction

  task automatic model_step();
    bit t;
    bit bs;
    t  = m_en();
    bs = m_bpstop();
    if (rst) begin
      m_mode = 0; m_rem = 0; m_left = 0; m_skip = 0; m_bp = 0; m_done = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (t) begin
        m_cnt  = m_cnt + 1;
        m_skip = 0;
      end
      if (cmd_valid && cmd == 2'd3) begin
        m_mode = 3; m_left = RST_CYCLES; m_cnt = 0; m_bp = 0; m_skip = 0; m_rem = 0;
      end else if (m_mode == 3) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end else if (cmd_valid) begin
        if (cmd == 2'd0) m_mode = 0;
        else if (cmd == 2'd1) begin
          m_mode = 1; m_bp = 0; m_skip = 1;
        end else begin
          m_bp = 0; m_skip = 1; m_rem = step_num;
          if (step_num == 0) begin
            m_mode = 0; m_done = 1;
          end else m_mode = 2;
        end
      end else if ((m_mode == 1 || m_mode == 2) && bs) begin
        m_mode = 0; m_bp = 1; m_done = 1;
      end else if (m_mode == 2 && t && cu_state) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode = 0; m_done = 1;
        end
      end
    end
  endtask

  // one clock: advance model on the edge, drive new inputs, settle to the falling edge
  task automatic apply(input bit r, input bit v, input logic [1:0] c, input logic [7:0] sn,
                       input bit cs, input bit fr, input logic [11:0] pc);
    @(posedge clk);
    model_step();
    #1;
    rst = r; cmd_valid = v; cmd = c; step_num = sn;
    cu_state = cs; flash_ready = fr; pc_out = pc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bp_en = 1'b0; pc_valid = 1'b0; bp_addr = 12'h000;
    apply(1, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    apply(1, 0, 2'd0, 8'd0, 0, 1, 12'h000);
  endtask

  task automatic test_reset();
    apply(1, 1, 2'd1, 8'd3, 1, 1, 12'h000);
    apply(1, 1, 2'd2, 8'd3, 1, 1, 12'h000);
    checks++;
    if (uc_rst !== 1'b1 || uc_clk_en !== 1'b0 || run_state !== 2'd0 || bp_hit !== 1'b0 ||
        done !== 1'b0 || cycle_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold got rst=%b en=%b st=%0d bp=%b done=%b cnt=%0d want 1 0 0 0 0 0",
               uc_rst, uc_clk_en, run_state, bp_hit, done, cycle_cnt);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    checks++;
    if (uc_rst !== 1'b0 || run_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_release got rst=%b st=%0d want 0 0", uc_rst, run_state);
    end
  endtask

  task automatic test_step3();
    int dones;
    int ens;
    do_reset();
    dones = 0; ens = 0;
    apply(0, 1, 2'd2, 8'd3, 0, 1, 12'h000);
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 2'd0, 8'd0, bit'(i % 2), 1, 12'h000);
      ens += int'(uc_clk_en);
      dones += int'(done);
    end
    checks++;
    if (ens != 6) begin
      errors++;
      $display("FAIL step3_ticks got %0d want 6", ens);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    dones += int'(done);
    checks++;
    if (run_state !== 2'd0 || cycle_cnt !== 32'd6 || done !== 1'b1) begin
      errors++;
      $display("FAIL step3_end got st=%0d cnt=%0d done=%b want 0 6 1", run_state, cycle_cnt, done);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    dones += int'(done);
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL step3_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_breakpoint();
    int dones;
    do_reset();
    bp_en = 1'b1; bp_addr = 12'h010; pc_valid = 1'b1; dones = 0;
    apply(0, 1, 2'd1, 8'd0, 0, 1, 12'h00C);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h00C);
    apply(0, 0, 2'd0, 8'd0, 1, 1, 12'h00C);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h00E);
    apply(0, 0, 2'd0, 8'd0, 1, 1, 12'h00E);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h010);
    checks++;
    if (uc_clk_en !== 1'b0 || run_state !== 2'd1) begin
      errors++;
      $display("FAIL bp_no_tick got en=%b st=%0d want 0 1", uc_clk_en, run_state);
    end
    apply(0, 1, 2'd1, 8'd0, 0, 1, 12'h010);
    checks++;
    if (run_state !== 2'd0 || bp_hit !== 1'b1 || done !== 1'b1 || cycle_cnt !== 32'd4) begin
      errors++;
      $display("FAIL bp_halt got st=%0d bp=%b done=%b cnt=%0d want 0 1 1 4",
               run_state, bp_hit, done, cycle_cnt);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h010);
    checks++;
    if (uc_clk_en !== 1'b1 || run_state !== 2'd1 || bp_hit !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume got en=%b st=%0d bp=%b done=%b want 1 1 0 0",
               uc_clk_en, run_state, bp_hit, done);
    end
    apply(0, 0, 2'd0, 8'd0, 1, 1, 12'h010);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h012);
    checks++;
    if (uc_clk_en !== 1'b1) begin
      errors++;
      $display("FAIL bp_pass got en=%b want 1", uc_clk_en);
    end
    apply(0, 0, 2'd0, 8'd0, 1, 1, 12'h012);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h010);
    checks++;
    if (uc_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_recur_tick got en=%b want 0", uc_clk_en);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h010);
    dones += int'(done);
    checks++;
    if (run_state !== 2'd0 || bp_hit !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_recur got st=%0d bp=%b done=%b want 0 1 1", run_state, bp_hit, done);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h010);
    dones += int'(done);
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL bp_done_count got %0d want 1", dones);
    end
    bp_en = 1'b0; pc_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int dones;
    int hold;
    do_reset();
    dones = 0; hold = 0;
    apply(0, 1, 2'd1, 8'd0, 0, 1, 12'h000);
    for (int i = 0; i < 25; i++) apply(0, 0, 2'd0, 8'd0, bit'(i % 2), 1, 12'h000);
    apply(0, 1, 2'd3, 8'd0, 1, 1, 12'h000);
    checks++;
    if (cycle_cnt !== 32'd25) begin
      errors++;
      $display("FAIL rst_run_cnt got %0d want 25", cycle_cnt);
    end
    for (int i = 0; i < RST_CYCLES; i++) begin
      apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
      hold += int'(uc_rst === 1'b1 && run_state === 2'd3 && cycle_cnt === 32'd0);
      dones += int'(done);
    end
    checks++;
    if (hold != RST_CYCLES) begin
      errors++;
      $display("FAIL rst_run_hold got %0d want %0d", hold, RST_CYCLES);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    dones += int'(done);
    checks++;
    if (uc_rst !== 1'b0 || run_state !== 2'd0 || dones != 0) begin
      errors++;
      $display("FAIL rst_run_exit got rst=%b st=%0d dones=%0d want 0 0 0", uc_rst, run_state, dones);
    end
  endtask

  task automatic test_stall();
    int stall_ok;
    do_reset();
    stall_ok = 0;
    apply(0, 1, 2'd2, 8'd1, 0, 1, 12'h000);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 2'd0, 8'd0, 0, 0, 12'h000);
      stall_ok += int'(uc_clk_en === 1'b0 && run_state === 2'd2);
    end
    checks++;
    if (stall_ok != 3) begin
      errors++;
      $display("FAIL stall_hold got %0d want 3", stall_ok);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    apply(0, 0, 2'd0, 8'd0, 1, 0, 12'h000);
    checks++;
    if (uc_clk_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_exec got en=%b want 1", uc_clk_en);
    end
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    checks++;
    if (run_state !== 2'd0 || done !== 1'b1 || cycle_cnt !== 32'd2) begin
      errors++;
      $display("FAIL stall_end got st=%0d done=%b cnt=%0d want 0 1 2", run_state, done, cycle_cnt);
    end
  endtask

  task automatic test_halt_on_retire();
    do_reset();
    apply(0, 1, 2'd2, 8'd1, 0, 1, 12'h000);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    apply(0, 1, 2'd0, 8'd0, 1, 1, 12'h000);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    checks++;
    if (run_state !== 2'd0 || done !== 1'b0 || cycle_cnt !== 32'd2) begin
      errors++;
      $display("FAIL halt_retire got st=%0d done=%b cnt=%0d want 0 0 2", run_state, done, cycle_cnt);
    end
  endtask

  task automatic test_step_zero();
    do_reset();
    apply(0, 1, 2'd2, 8'd0, 0, 1, 12'h000);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    checks++;
    if (run_state !== 2'd0 || done !== 1'b1 || uc_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL step_zero got st=%0d done=%b en=%b want 0 1 0", run_state, done, uc_clk_en);
    end
  endtask

  task automatic test_cmd_in_rst();
    int in_rst;
    do_reset();
    in_rst = 0;
    apply(0, 1, 2'd3, 8'd0, 0, 1, 12'h000);
    apply(0, 1, 2'd1, 8'd0, 0, 1, 12'h000);
    in_rst += int'(run_state === 2'd3);
    apply(0, 1, 2'd2, 8'd4, 0, 1, 12'h000);
    in_rst += int'(run_state === 2'd3);
    apply(0, 1, 2'd0, 8'd0, 0, 1, 12'h000);
    in_rst += int'(run_state === 2'd3);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    in_rst += int'(run_state === 2'd3);
    apply(0, 0, 2'd0, 8'd0, 0, 1, 12'h000);
    checks++;
    if (in_rst != 4 || run_state !== 2'd0 || uc_rst !== 1'b0) begin
      errors++;
      $display("FAIL rst_ignore got held=%0d st=%0d rst=%b want 4 0 0", in_rst, run_state, uc_rst);
    end
  endtask

  task automatic test_random();
    logic [11:0] pc;
    logic [1:0]  c;
    do_reset();
    bp_addr = 12'h010;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) bp_en = 1'($urandom);
      pc_valid = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0:       pc = 12'h010;
        1:       pc = 12'h012;
        default: pc = 12'($urandom_range(0, 31));
      endcase
      c = 2'($urandom);
      if (c == 2'd3 && $urandom_range(0, 3) != 0) c = 2'($urandom_range(0, 2));
      apply(bit'($urandom_range(0, 199) == 0), bit'($urandom_range(0, 5) == 0), c,
            8'($urandom_range(0, 5)), bit'($urandom), bit'($urandom_range(0, 3) != 0), pc);
      checks++;
      if (uc_clk_en !== m_en() || run_state !== 2'(m_mode) || uc_rst !== (rst || m_mode == 3) ||
          bp_hit !== m_bp || done !== m_done || cycle_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random_cycle%0d got en=%b st=%0d rst=%b bp=%b done=%b cnt=%0d want %b %0d %b %b %b %0d",
                 i, uc_clk_en, run_state, uc_rst, bp_hit, done, cycle_cnt,
                 m_en(), m_mode, (rst || m_mode == 3), m_bp, m_done, m_cnt);
      end
    end
    bp_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; step_num = 8'd0; bp_en = 1'b0;
    bp_addr = 12'h000; pc_out = 12'h000; pc_valid = 1'b0; cu_state = 1'b0; flash_ready = 1'b1;
    test_reset();
    test_step3();
    test_breakpoint();
    test_reset_mid_run();
    test_stall();
    test_halt_on_retire();
    test_step_zero();
    test_cmd_in_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
